// File: rtl/focal_delay_pkg.sv
// Shared types and constants for the focal delay accumulator.
// Element n of a scan line maps to register index CENTER+n.
package focal_delay_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        WAIT_TERM,
        ADD,
        STEP,
        WRITE,
        POINT_DONE
    } state_t;

    localparam int NUM_ELEM        = 63;
    localparam int CENTER          = 31;
    localparam int PAIRS_PER_POINT = 32;

    function automatic logic [5:0] elem_index(input logic [4:0] pair, input logic neg);
        if (neg) begin
            return 6'(CENTER - int'(pair));
        end
        return 6'(CENTER + int'(pair));
    endfunction

endpackage

// File: rtl/focal_delay_accumulator_threshold_step_unit.sv
// Combinational arithmetic for the ADD and STEP phases: saturating add,
// threshold subtract, step-limit clamp and saturating delay increment.
module threshold_step_unit #(
    parameter int AW        = 28,
    parameter int TW        = 27,
    parameter int DW_DELAY  = 10,
    parameter int SW        = 2,
    parameter int THRESH    = 4096,
    parameter int MAX_STEPS = 3
) (
    input  logic [AW-1:0]       acc_i,
    input  logic [TW-1:0]       term_i,
    output logic [AW-1:0]       sum_o,
    output logic                sum_needs_step_o,
    input  logic [AW-1:0]       s_i,
    input  logic [DW_DELAY-1:0] delay_i,
    input  logic [SW-1:0]       steps_i,
    output logic [AW-1:0]       step_s_o,
    output logic [DW_DELAY-1:0] step_delay_o,
    output logic                step_done_o,
    output logic                step_ovf_o
);

    localparam logic signed [AW-1:0] THRESH_S = AW'(THRESH);
    localparam logic signed [AW-1:0] S_MAX    = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] S_MIN    = {1'b1, {(AW-1){1'b0}}};

    logic signed [AW:0]   wide;
    logic signed [AW-1:0] s_sub;
    logic                 more;
    logic                 last;
    logic                 dly_sat;

    always_comb begin
        wide = $signed({acc_i[AW-1], acc_i}) + $signed({{(AW+1-TW){term_i[TW-1]}}, term_i});
        // One extra bit of headroom; clip back to AW bits at either rail.
        if (wide[AW] != wide[AW-1]) begin
            sum_o = wide[AW] ? S_MIN : S_MAX;
        end else begin
            sum_o = wide[AW-1:0];
        end
        sum_needs_step_o = $signed(sum_o) >= THRESH_S;

        s_sub        = $signed(s_i) - THRESH_S;
        more         = s_sub >= THRESH_S;
        last         = (steps_i + SW'(1)) == SW'(MAX_STEPS);
        dly_sat      = &delay_i;
        step_delay_o = dly_sat ? delay_i : delay_i + DW_DELAY'(1);
        step_s_o     = (more && last) ? AW'(THRESH - 1) : s_sub;
        step_done_o  = !more || last;
        step_ovf_o   = (more && last) || dly_sat;
    end

endmodule

// File: rtl/focal_delay_accumulator.sv
// Consumes pos/neg increment-term pairs, accumulates per-element error and
// steps the integer sample delay of each element on threshold crossings.
//
// state      | meaning
// IDLE       | waiting for start
// CONFIG     | term_configure pulse to the calculator
// WAIT_TERM  | waiting for term_ready, latch pair and ack
// ADD        | s = acc[e] + term
// STEP       | one threshold subtract / delay increment per cycle
// WRITE      | acc[e] <= s, pick next element or pair
// POINT_DONE | point_valid pulse, next point or back to IDLE
module focal_delay_accumulator
    import focal_delay_pkg::*;
#(
    parameter int DW_INTEGER  = 18,
    parameter int DW_FRACTION = 8,
    parameter int DW_DELAY    = 10,
    parameter int DW_POINT    = 8,
    parameter int THRESH      = 4096,
    parameter int MAX_STEPS   = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [DW_POINT-1:0]               num_points,
    output logic                              term_configure,
    input  logic [DW_INTEGER+DW_FRACTION:0]   term_pos,
    input  logic [DW_INTEGER+DW_FRACTION:0]   term_neg,
    input  logic                              term_ready,
    output logic                              term_ack,
    input  logic [5:0]                        rd_addr,
    output logic [DW_DELAY-1:0]               rd_data,
    output logic                              point_valid,
    output logic [DW_POINT-1:0]               point_index,
    output logic                              busy,
    output logic                              overflow
);

    localparam int TW = DW_INTEGER + DW_FRACTION + 1;
    localparam int AW = TW + 1;
    localparam int SW = $clog2(MAX_STEPS + 1);

    state_t              state_q;
    logic [TW-1:0]       pos_q;
    logic [TW-1:0]       neg_q;
    logic [AW-1:0]       s_q;
    logic [SW-1:0]       steps_q;
    logic [4:0]          pair_q;
    logic                neg_phase_q;
    logic [5:0]          elem_q;
    logic [DW_POINT-1:0] num_q;
    logic [DW_POINT-1:0] point_index_q;
    logic                term_configure_q;
    logic                term_ack_q;
    logic                point_valid_q;
    logic                overflow_q;

    logic [AW-1:0]       acc_q   [NUM_ELEM];
    logic [DW_DELAY-1:0] delay_q [NUM_ELEM];

    logic [AW-1:0]       sum;
    logic                sum_needs_step;
    logic [AW-1:0]       step_s;
    logic [DW_DELAY-1:0] step_delay;
    logic                step_done;
    logic                step_ovf;

    threshold_step_unit #(
        .AW        (AW),
        .TW        (TW),
        .DW_DELAY  (DW_DELAY),
        .SW        (SW),
        .THRESH    (THRESH),
        .MAX_STEPS (MAX_STEPS)
    ) u_step (
        .acc_i            (acc_q[elem_q]),
        .term_i           (neg_phase_q ? neg_q : pos_q),
        .sum_o            (sum),
        .sum_needs_step_o (sum_needs_step),
        .s_i              (s_q),
        .delay_i          (delay_q[elem_q]),
        .steps_i          (steps_q),
        .step_s_o         (step_s),
        .step_delay_o     (step_delay),
        .step_done_o      (step_done),
        .step_ovf_o       (step_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            pos_q            <= '0;
            neg_q            <= '0;
            s_q              <= '0;
            steps_q          <= '0;
            pair_q           <= '0;
            neg_phase_q      <= 1'b0;
            elem_q           <= '0;
            num_q            <= '0;
            point_index_q    <= '0;
            term_configure_q <= 1'b0;
            term_ack_q       <= 1'b0;
            point_valid_q    <= 1'b0;
            overflow_q       <= 1'b0;
            for (int i = 0; i < NUM_ELEM; i++) begin
                acc_q[i]   <= '0;
                delay_q[i] <= '0;
            end
        end else begin
            term_configure_q <= 1'b0;
            term_ack_q       <= 1'b0;
            point_valid_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        overflow_q       <= 1'b0;
                        num_q            <= (num_points == '0) ? DW_POINT'(1) : num_points;
                        point_index_q    <= '0;
                        pair_q           <= '0;
                        term_configure_q <= 1'b1;
                        state_q          <= CONFIG;
                    end
                end
                CONFIG: state_q <= WAIT_TERM;
                WAIT_TERM: begin
                    if (term_ready) begin
                        pos_q       <= term_pos;
                        neg_q       <= term_neg;
                        term_ack_q  <= 1'b1;
                        neg_phase_q <= 1'b0;
                        elem_q      <= elem_index(pair_q, 1'b0);
                        state_q     <= ADD;
                    end
                end
                ADD: begin
                    s_q     <= sum;
                    steps_q <= '0;
                    state_q <= sum_needs_step ? STEP : WRITE;
                end
                STEP: begin
                    s_q             <= step_s;
                    delay_q[elem_q] <= step_delay;
                    steps_q         <= steps_q + SW'(1);
                    if (step_ovf) overflow_q <= 1'b1;
                    if (step_done) state_q <= WRITE;
                end
                WRITE: begin
                    acc_q[elem_q] <= s_q;
                    // Pair 0 is the centre element alone; its neg term is dropped.
                    if (!neg_phase_q && pair_q != '0) begin
                        neg_phase_q <= 1'b1;
                        elem_q      <= elem_index(pair_q, 1'b1);
                        state_q     <= ADD;
                    end else if (pair_q == 5'(PAIRS_PER_POINT - 1)) begin
                        point_valid_q <= 1'b1;
                        state_q       <= POINT_DONE;
                    end else begin
                        pair_q  <= pair_q + 5'd1;
                        state_q <= WAIT_TERM;
                    end
                end
                POINT_DONE: begin
                    if (({1'b0, point_index_q} + (DW_POINT+1)'(1)) < {1'b0, num_q}) begin
                        point_index_q <= point_index_q + DW_POINT'(1);
                        pair_q        <= '0;
                        state_q       <= WAIT_TERM;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr != 6'd63) rd_data = delay_q[rd_addr];
    end

    assign term_configure = term_configure_q;
    assign term_ack       = term_ack_q;
    assign point_valid    = point_valid_q;
    assign point_index    = point_index_q;
    assign busy           = (state_q != IDLE);
    assign overflow       = overflow_q;

endmodule

// File: doc/focal_delay_accumulator.md
# focal_delay_accumulator

Consumer end of the increment-term handshake. It starts the term calculator for a scan line and accepts each pos/neg term pair with a one-cycle acknowledge. Each term is accumulated into a per-element error register, and an integer sample-delay counter is stepped whenever the accumulated error crosses a fixed-point threshold. The block sits between the increment-term calculator and the transmit/receive delay table, which reads delays through a combinational read port.

## Interface
Parameters:
- DW_INTEGER, 18, integer bits of incoming term
- DW_FRACTION, 8, fraction bits of incoming term
- DW_DELAY, 10, width of per-element delay counter
- DW_POINT, 8, width of point count/index
- THRESH, 4096, step threshold in term units (16.0 in Q.8)
- MAX_STEPS, 3, max delay increments per element per point

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a scan line; ignored unless idle
- num_points  in  DW_POINT  points per scan line; sampled on start; 0 is treated as 1
- term_configure  out  1  one-cycle pulse to term calculator
- term_pos  in  DW_INTEGER+DW_FRACTION+1  signed term for element +n
- term_neg  in  DW_INTEGER+DW_FRACTION+1  signed term for element −n
- term_ready  in  1  term pair valid
- term_ack  out  1  one-cycle acknowledge of the latched pair
- rd_addr  in  6  element index 0..62; element n maps to 31+n; 63 returns 0
- rd_data  out  DW_DELAY  delay of addressed element, combinational
- point_valid  out  1  one-cycle pulse when all 63 elements are updated for a point
- point_index  out  DW_POINT  index of completed point, valid with point_valid
- busy  out  1  high outside IDLE
- overflow  out  1  sticky; cleared on start or reset

## Operation
- **Reset:**
  - All outputs are 0.
  - All accumulators and delays are 0.
  - State is IDLE.
  - Reset mid-operation aborts immediately; no ack is issued in that cycle.
- **IDLE:** start goes to CONFIG, clears overflow, and latches num_points.
  - Accumulators and delays are not cleared; they are cleared only by reset.
- **CONFIG:** drive term_configure for 1 cycle, then go to WAIT_TERM.
- **WAIT_TERM:** on term_ready, latch term_pos/term_neg and pulse term_ack for exactly 1 cycle, then go to ADD.
  - term_ack never asserts in two consecutive cycles.
- **Pair order per point is fixed at 32 pairs:**
  - Pair 0 is n=0. Only term_pos is applied, to element 31; term_neg is discarded.
  - Pairs 1..31 are n=1..31. term_pos is applied to element 31+n, then term_neg to element 31−n.
- **ADD:** s = acc[e] + term, computed at width DW_INTEGER+DW_FRACTION+2, signed.
- **STEP:** while s ≥ THRESH and steps < MAX_STEPS, perform s −= THRESH and delay[e] += 1, one iteration per cycle.
  - If s ≥ THRESH remains after MAX_STEPS, clamp s to THRESH−1 and set overflow.
  - If s < 0, no step occurs; s is kept and saturates at the signed minimum.
  - delay saturates at all-ones; a saturating increment sets overflow.
- **WRITE:** acc[e] ← s. Then the next element (neg of the same pair) goes to ADD, or the FSM returns to WAIT_TERM.
- **POINT_DONE:** after pair 31's neg write, pulse point_valid with point_index.
  - If point_index+1 < num_points, increment point_index and go to WAIT_TERM.
  - Otherwise go to IDLE. The calculator's next pending pair is left unacknowledged; the calculator is re-armed by system reset.
- **Simultaneous events:** start while busy is ignored. term_ready outside WAIT_TERM is ignored, and the pair is held by the calculator.

## Timing
- start → term_configure: 1 cycle later (CONFIG).
- term_ready seen in WAIT_TERM → term_ack in the same cycle as the latch (registered, asserted the cycle after WAIT_TERM samples ready).
- Per element: 1 (ADD) + k (STEP, k = 0..MAX_STEPS) + 1 (WRITE) cycles.
- point_valid: 1 cycle after the last WRITE of the point.
- rd_data reflects a WRITE/STEP on the following cycle.

## Structure
- Shared package `focal_delay_pkg` holds:
  - state enum: IDLE, CONFIG, WAIT_TERM, ADD, STEP, WRITE, POINT_DONE
  - NUM_ELEM=63, CENTER=31, PAIRS_PER_POINT=32
  - element-index helper
- One sub-module, `threshold_step_unit`, implements the ADD/STEP arithmetic: saturation, clamp, step count and overflow flag.
- The register file of 63 × (acc, delay) stays in the top level.

## Test plan
- Reset, then start with num_points=1 → term_configure 1 cycle after start; 32 acks, each 1 cycle wide; point_valid with point_index=0; return to IDLE.
- Pair 0 term_pos=0x1000 → delay[31]=1, acc[31]=0; term_neg=0x7FFF ignored with no effect on other elements.
- n=5: pos=0x2800, neg=0x0800 → delay[36]=2 and acc[36]=0x0800; delay[26]=0 and acc[26]=0x0800. Element 36 takes 4 cycles.
- term=0x5000 on element 40 → delay+3, acc=0x0FFF, overflow=1. overflow stays set until the next start.
- Negative term −0x0400 → no step, acc=−0x0400; a following term of 0x1400 → one step, acc=0.
- Deassert rst_n during STEP → next cycle all outputs 0 and all delays 0; start afterwards runs cleanly. A start pulse while busy produces no second term_configure.
